elevator_scheduler: RTL and testbench



---
 rtl/elevator_scheduler.sv | 130 +++++++++++++
 tb/tb_elevator_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - single-car SCAN elevator sequencer over 10 floors
module elevator_scheduler #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] call,
    output logic [3:0] floor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic [9:0] pending,
    output logic       done
);

    localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    // A one-cycle maximum would give a zero-width timer, so keep at least one bit.
    localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [3:0]    floor_nx;
    logic          dir_nx;
    logic [9:0]    req;
    logic [9:0]    clr;
    logic [9:0]    pending_nx;

    // True when any request lies strictly beyond floor f in the given direction.
    function automatic logic ahead_of(input logic [9:0] r, input logic [3:0] f, input logic up);
        ahead_of = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (r[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
                ahead_of = 1'b1;
            end
        end
    endfunction

    // State, position, direction, timer and request register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            floor   <= 4'd0;
            dir_up  <= 1'b1;
            timer   <= '0;
            pending <= '0;
        end else begin
            state   <= state_nx;
            floor   <= floor_nx;
            dir_up  <= dir_nx;
            timer   <= timer_nx;
            pending <= pending_nx;
        end
    end

    // SCAN decision: next state, floor step, direction and the floor's request clear.
    always_comb begin
        req      = pending | call;
        state_nx = state;
        timer_nx = timer;
        floor_nx = floor;
        dir_nx   = dir_up;
        case (state)
            S_IDLE: begin
                if (req[floor]) begin
                    state_nx = S_DOOR;
                    timer_nx = DOOR_LOAD;
                end else if (ahead_of(req, floor, dir_up)) begin
                    state_nx = S_MOVE;
                    timer_nx = MOVE_LOAD;
                end else if (ahead_of(req, floor, ~dir_up)) begin
                    dir_nx   = ~dir_up;
                    state_nx = S_MOVE;
                    timer_nx = MOVE_LOAD;
                end
            end
            S_MOVE: begin
                if (timer != '0) begin
                    timer_nx = timer - 1'b1;
                end else begin
                    // Range guard keeps the car on 0..9 even if requests vanished.
                    if (dir_up && (floor != 4'd9)) begin
                        floor_nx = floor + 4'd1;
                    end else if (!dir_up && (floor != 4'd0)) begin
                        floor_nx = floor - 4'd1;
                    end
                    if (req[floor_nx]) begin
                        state_nx = S_DOOR;
                        timer_nx = DOOR_LOAD;
                    end else if (ahead_of(req, floor_nx, dir_up)) begin
                        state_nx = S_MOVE;
                        timer_nx = MOVE_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (timer != '0) begin
                    timer_nx = timer - 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
        // Calls for the floor where the door is (or is about to be) open are absorbed.
        clr        = ((state == S_DOOR) || (state_nx == S_DOOR)) ? (10'd1 << floor_nx) : 10'd0;
        pending_nx = req & ~clr;
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        moving    = (state == S_MOVE);
        door_open = (state == S_DOOR);
        done      = (state == S_IDLE) && (pending == 10'd0);
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - randomized and directed bench for elevator_scheduler
module tb_elevator_scheduler;

    localparam int M = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] call;
    logic [3:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [9:0] pending;
    logic       done;

    elevator_scheduler #(.MOVE_CYCLES(M), .DOOR_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model: the car is either resting, travelling or parked with the door open,
    // with a count of cycles left in the current travel leg or door dwell.
    localparam int REST = 0, TRAVEL = 1, DWELL = 2;
    int       m_floor;
    int       m_mode;
    int       m_left;
    bit       m_up;
    bit [9:0] m_pend;

    function automatic bit wants(input bit [9:0] r, input int f, input bit up);
        int rr;
        rr = int'(r);
        if (up) return (rr >> (f + 1)) != 0;
        return (rr & ((1 << f) - 1)) != 0;
    endfunction

    task automatic model_tick(input bit [9:0] c, input bit r);
        bit [9:0] req;
        bit       was_dwell;
        if (r) begin
            m_floor = 0; m_mode = REST; m_left = 0; m_up = 1'b1; m_pend = '0;
            return;
        end
        req       = m_pend | c;
        was_dwell = (m_mode == DWELL);
        if (m_mode == REST) begin
            if (req[m_floor]) begin
                m_mode = DWELL; m_left = D;
            end else if (wants(req, m_floor, m_up)) begin
                m_mode = TRAVEL; m_left = M;
            end else if (wants(req, m_floor, !m_up)) begin
                m_up = !m_up; m_mode = TRAVEL; m_left = M;
            end
        end else if (m_mode == TRAVEL) begin
            if (m_left > 1) m_left--;
            else begin
                m_floor += m_up ? 1 : -1;
                if (req[m_floor]) begin
                    m_mode = DWELL; m_left = D;
                end else if (wants(req, m_floor, m_up)) m_left = M;
                else m_mode = REST;
            end
        end else begin
            if (m_left > 1) m_left--;
            else m_mode = REST;
        end
        if (was_dwell || m_mode == DWELL) req[m_floor] = 1'b0;
        m_pend = req;
    endtask

    task automatic step(input logic [9:0] c, input logic r);
        call = c;
        rst  = r;
        @(posedge clk);
        model_tick(c, r);
        #1;
        check("floor", floor, m_floor);
        check("dir_up", dir_up, m_up);
        check("moving", moving, m_mode == TRAVEL);
        check("door_open", door_open, m_mode == DWELL);
        check("pending", pending, m_pend);
        check("done", done, (m_mode == REST) && (m_pend == 0));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(10'd0, 1'b0);
    endtask

    int stops[$];
    int max_floor;

    task automatic run_until_done();
        logic prev;
        stops.delete();
        max_floor = int'(floor);
        prev = door_open;
        for (int i = 0; i < 400; i++) begin
            step(10'd0, 1'b0);
            if (door_open && !prev) stops.push_back(int'(floor));
            prev = door_open;
            if (int'(floor) > max_floor) max_floor = int'(floor);
            if (done) break;
        end
        check("run_timeout", done, 1'b1);
    endtask

    logic [9:0] rc;
    logic       rr;

    initial begin
        call = '0;
        rst  = 1'b1;

        // Reset state
        step(10'd0, 1'b1);
        check("rst_floor", floor, 0);
        check("rst_dir", dir_up, 1);
        check("rst_done", done, 1);
        check("rst_pending", pending, 0);

        // Single call to floor 3 from floor 0
        step(10'h008, 1'b0);
        check("t1_pending", pending, 10'h008);
        check("t1_moving", moving, 1);
        idle_steps(3);
        check("t1_still0", floor, 0);
        idle_steps(1);
        check("t1_floor1", floor, 1);
        idle_steps(4);
        check("t1_floor2", floor, 2);
        idle_steps(4);
        check("t1_floor3", floor, 3);
        check("t1_door", door_open, 1);
        check("t1_clear", pending, 0);
        idle_steps(2);
        check("t1_door_last", door_open, 1);
        idle_steps(1);
        check("t1_closed", door_open, 0);
        check("t1_done", done, 1);

        // Call at the current floor
        step(10'd0, 1'b1);
        step(10'h001, 1'b0);
        check("t2_door", door_open, 1);
        check("t2_pending", pending, 0);
        idle_steps(2);
        check("t2_door3", door_open, 1);
        check("t2_floor", floor, 0);
        idle_steps(1);
        check("t2_done", done, 1);

        // SCAN: heading to 8, calls 5 and 1 while at floor 2
        step(10'd0, 1'b1);
        step(10'h100, 1'b0);
        idle_steps(8);
        check("t3_at2", floor, 2);
        step(10'h022, 1'b0);
        run_until_done();
        check("t3_nstops", stops.size(), 3);
        if (stops.size() == 3) begin
            check("t3_stop0", stops[0], 5);
            check("t3_stop1", stops[1], 8);
            check("t3_stop2", stops[2], 1);
        end
        check("t3_dir", dir_up, 0);

        // Call arriving exactly as the car reaches floor 4
        step(10'd0, 1'b1);
        step(10'h100, 1'b0);
        idle_steps(15);
        step(10'h010, 1'b0);
        check("t4_floor", floor, 4);
        check("t4_door", door_open, 1);
        run_until_done();
        check("t4_nstops", stops.size(), 1);
        if (stops.size() == 1) check("t4_stop", stops[0], 8);

        // One cycle late: served on the way back
        step(10'd0, 1'b1);
        step(10'h100, 1'b0);
        idle_steps(16);
        step(10'h010, 1'b0);
        check("t4l_door", door_open, 0);
        check("t4l_moving", moving, 1);
        run_until_done();
        check("t4l_nstops", stops.size(), 2);
        if (stops.size() == 2) begin
            check("t4l_stop0", stops[0], 8);
            check("t4l_stop1", stops[1], 4);
        end

        // Reset mid-travel between 6 and 7
        step(10'd0, 1'b1);
        step(10'h380, 1'b0);
        idle_steps(24);
        step(10'h040, 1'b0);
        check("t5_pending", pending, 10'h3C0);
        check("t5_floor", floor, 6);
        step(10'd0, 1'b1);
        check("t5_floor0", floor, 0);
        check("t5_pend0", pending, 0);
        check("t5_moving", moving, 0);
        check("t5_door", door_open, 0);
        check("t5_dir", dir_up, 1);
        check("t5_done", done, 1);

        // Calls 0 and 9 together
        step(10'h201, 1'b0);
        check("t6_door0", door_open, 1);
        check("t6_floor0", floor, 0);
        check("t6_pending", pending, 10'h200);
        run_until_done();
        check("t6_nstops", stops.size(), 1);
        if (stops.size() == 1) check("t6_stop", stops[0], 9);
        check("t6_max", max_floor, 9);

        // Random traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            rc = ($urandom_range(0, 5) == 0) ? 10'($urandom) : 10'd0;
            rr = ($urandom_range(0, 399) == 0);
            step(rc, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
